fifo_ram: RTL and testbench
===========================

// Module: fifo_ram
// PURPOSE
//   Synchronous single-clock FIFO built on an internal register-array RAM.
//   It provides first-word-fall-through (FWFT) reads: the head entry is always visible on o_rd_data.
//   It exposes full/empty flags and an occupancy count.
//   It is the general buffering element of the packet-processing datapath, placed between producer and consumer stages.
// PARAMETERS
//   WIDTH       8    data word width in bits
//   DEPTH       16   number of entries; must be a power of two and >= 2
//   ADDR_WIDTH  $clog2(DEPTH)   localparam, not overridable; pointer width
// PORTS
//   i_clk      in   1             single clock; all state changes on its rising edge
//   i_rst      in   1             asynchronous, active-low reset
//   i_wr_data  in   WIDTH         write data
//   i_wr_en    in   1             write request
//   i_rd_en    in   1             read (pop) request
//   o_rd_data  out  WIDTH         head-of-FIFO data (FWFT, combinational from RAM)
//   o_empty    out  1             high when count == 0
//   o_full     out  1             high when count == DEPTH
//   o_count    out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//   Reset (i_rst low, asynchronous):
//     - wr_ptr, rd_ptr and count clear to 0
//     - o_empty=1, o_full=0, o_count=0
//     - RAM contents are not cleared
//     - a reset asserted mid-operation discards all stored entries immediately
//   Write acceptance:
//     - a write is accepted at a rising edge when i_wr_en=1 and o_full=0
//     - on acceptance, mem[wr_ptr] <= i_wr_data and wr_ptr increments
//   Read acceptance:
//     - a read is accepted when i_rd_en=1 and o_empty=0
//     - on acceptance, rd_ptr increments
//   Flag sampling:
//     - acceptance uses flags as they stood before the edge
//     - a write while full is dropped, even when a read occurs in the same cycle
//     - a read while empty is ignored; a simultaneous write still occurs
//   o_rd_data:
//     - o_rd_data = mem[rd_ptr] combinationally, so the data is valid in the same cycle i_rd_en is asserted
//     - the consumer samples o_rd_data before the popping edge
//     - while empty, o_rd_data is stale/undefined and must not be used
//   Pointers: ADDR_WIDTH bits wide; wrap naturally from DEPTH-1 to 0.
//   Count update (registered, changes on the same edge as the accepted operation):
//     - +1 on write only
//     - -1 on read only
//     - unchanged on a simultaneous accepted read and write, or with no activity
//   o_empty and o_full are decoded combinationally from the registered count.
//   Latency:
//     - a written word is visible on o_rd_data the cycle after the write edge, when the FIFO was empty
//     - o_count and flags reflect an operation right after its edge
// STRUCTURE
//   - No shared package needed; ADDR_WIDTH is a local constant.
//   - One natural sub-module, fifo_ram_mem: DEPTH x WIDTH array with a synchronous write port and an asynchronous read port.
//   - The top level holds the pointers, count, flags and accept logic.
// TESTING
//   1. Reset: hold i_rst low 2 cycles -> o_empty=1, o_full=0, o_count=0.
//   2. Fill: write 0..15 on consecutive cycles -> o_count=1..16 after each edge; o_full=1 after the 16th; o_empty=0.
//   3. Overflow: write 8'hAA while full -> o_count stays 16 and the contents are unchanged.
//   4. Drain: i_rd_en=1 for 16 cycles -> o_rd_data=0..15 before each pop; o_empty=1 and o_count=0 after the last.
//   5. Alternate: 8x (write i, then next cycle read) -> o_rd_data==i at each read; count toggles 1/0.
//   6. Concurrency and wrap:
//      - with count=5, do a simultaneous read+write -> count stays 5 and the order is preserved
//      - the pointers wrap past 15 with correct data
//      - a read on empty plus a write -> count=1

Source files
------------

// File: rtl/fifo_ram_pkg.sv
// Shared types and default sizing for the register-array FIFO.
package fifo_ram_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 16;

   // Accepted-operation kind for one edge, encoded as {write, read}
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

endpackage : fifo_ram_pkg

// File: rtl/fifo_ram_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module fifo_ram_mem
   import fifo_ram_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is intentionally not reset; occupancy tracking makes stale words invisible
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Head word is read combinationally so it is valid in the popping cycle
   assign rd_data = mem[rd_addr];

endmodule : fifo_ram_mem

// File: rtl/fifo_ram.sv
// Single-clock first-word-fall-through FIFO with full/empty flags and occupancy count.
module fifo_ram
   import fifo_ram_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [WIDTH-1:0]      i_wr_data,
   input  logic                  i_wr_en,
   input  logic                  i_rd_en,
   output logic [WIDTH-1:0]      o_rd_data,
   output logic                  o_empty,
   output logic                  o_full,
   output logic [ADDR_WIDTH:0]   o_count
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_WIDTH-1:0]  count;
   logic                  wr_accept;
   logic                  rd_accept;
   fifo_op_e              op;

   // Flags decode from the registered count, so acceptance sees pre-edge state
   always_comb begin
      o_empty   = (count == '0);
      o_full    = (count == CNT_WIDTH'(DEPTH));
      wr_accept = i_wr_en & ~o_full;
      rd_accept = i_rd_en & ~o_empty;
      op        = fifo_op_e'({wr_accept, rd_accept});
   end

   assign o_count = count;

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         case (op)
            OP_WR:   count <= count + CNT_WIDTH'(1);
            OP_RD:   count <= count - CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   fifo_ram_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (i_clk),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr),
      .wr_data (i_wr_data),
      .rd_addr (rd_ptr),
      .rd_data (o_rd_data)
   );

endmodule : fifo_ram

// File: tb/tb_fifo_ram.sv
// Randomized and directed self-checking bench for fifo_ram against a queue reference model.
module tb_fifo_ram;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;

   logic             tb_clk;
   logic             rst_n;
   logic [WIDTH-1:0] wr_data;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             empty;
   logic             full;
   logic [4:0]       count;

   int unsigned checks;
   int unsigned failures;

   logic [WIDTH-1:0] model_q [$];

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .i_clk     (tb_clk),
      .i_rst     (rst_n),
      .i_wr_data (wr_data),
      .i_wr_en   (wr_en),
      .i_rd_en   (rd_en),
      .o_rd_data (rd_data),
      .o_empty   (empty),
      .o_full    (full),
      .o_count   (count)
   );

   // Free-running clock
   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare flags and count against the model occupancy
   task automatic chk_state(input string tag);
      int unsigned n;
      n = model_q.size();
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"},  32'(full),  32'(n == DEPTH));
   endtask

   // One clock of stimulus: checks the head before the edge, then the state after it
   task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] d,
                       input string tag);
      logic wr_ok;
      logic rd_ok;
      @(negedge tb_clk);
      wr_en   = wr;
      rd_en   = rd;
      wr_data = d;
      wr_ok   = wr && (model_q.size() < DEPTH);
      rd_ok   = rd && (model_q.size() > 0);
      if (rd_ok) begin
         chk({tag, ".rd_data"}, 32'(rd_data), 32'(model_q[0]));
      end
      @(posedge tb_clk);
      #1;
      if (rd_ok) void'(model_q.pop_front());
      if (wr_ok) model_q.push_back(d);
      chk_state(tag);
   endtask

   task automatic apply_reset();
      @(negedge tb_clk);
      rst_n = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      model_q.delete();
      repeat (2) @(posedge tb_clk);
      #1;
      chk_state("reset");
      @(negedge tb_clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wr_data  = '0;

      apply_reset();

      // Fill to full
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), "fill");
      // Overflow write is dropped
      step(1'b1, 1'b0, 8'hAA, "overflow");
      // Write while full with a read in the same cycle is still dropped
      step(1'b1, 1'b1, 8'hBB, "full_rw");
      // Drain remainder, checking order
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00, "drain");
      // Read on empty is ignored
      step(1'b0, 1'b1, 8'h00, "rd_empty");

      // Alternate write then read
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 8'(i), "alt_wr");
         step(1'b0, 1'b1, 8'h00, "alt_rd");
      end

      // Read on empty plus write: write still lands
      step(1'b1, 1'b1, 8'h5C, "rd_empty_wr");
      step(1'b0, 1'b1, 8'h00, "rd_empty_wr_pop");

      // Build count=5 then simultaneous read+write across the pointer wrap
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "pre5");
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h80 + i), "rw5");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "post5");

      // Random traffic with shifting bias to visit full and empty repeatedly
      for (int i = 0; i < 600; i++) begin
         int unsigned pw;
         int unsigned pr;
         pw = ((i / 60) % 2 == 0) ? 75 : 30;
         pr = ((i / 60) % 2 == 0) ? 30 : 75;
         step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
              8'($urandom), "rand");
      end

      // Asynchronous reset mid-operation discards contents immediately
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), "pre_rst");
      @(negedge tb_clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rst_n = 1'b0;
      model_q.delete();
      #1;
      chk_state("async_rst");
      @(negedge tb_clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'h3E, "post_rst_wr");
      step(1'b0, 1'b1, 8'h00, "post_rst_rd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_ram
